// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences an external WIDTH-bit shift register as a full-duplex synchronous serial port.
//
// Ports:
//   clk, rst_n            system clock (rising edge), asynchronous active-low reset
//   start, msb_first      transfer request and direction (1 = MSB first / shift left), sampled in IDLE
//   abort                 cancels any transfer in progress, sampled every cycle
//   tx_data               word to send, latched with start
//   busy, done            transfer in progress / one-cycle completion pulse
//   rx_data               last completed received word
//   sclk, sdo, sdi        serial clock (idle low), serial data out, serial data in
//   sr_cl, sr_w           shift-register clear and parallel write strobes
//   sr_shr, sr_shl        shift-register right/left shift strobes
//   sr_shift_bit          bit shifted into the vacated position
//   sr_din, sr_dout       shift-register parallel load data and current contents
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             msb_first,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             sdo,
    input  logic             sdi,
    output logic             sr_cl,
    output logic             sr_w,
    output logic             sr_shr,
    output logic             sr_shl,
    output logic             sr_shift_bit,
    output logic [WIDTH-1:0] sr_din,
    input  logic [WIDTH-1:0] sr_dout
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, BIT, FINISH, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             samp;
    logic             msb_lat;
    logic [WIDTH-1:0] tx_lat;
    logic             shift_now;

    // Last cycle of a serial bit period: the shift register moves on this edge,
    // so sdo only ever changes at the start of the following sclk-low half.
    assign shift_now = (state == BIT) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = abort ? CLEAR : (start ? LOAD : IDLE);
            LOAD:    state_nxt = abort ? CLEAR : BIT;
            BIT:     state_nxt = abort ? CLEAR : ((shift_now && bit_cnt == BIT_LAST) ? FINISH : BIT);
            FINISH:  state_nxt = abort ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        sr_w         = state == LOAD;
        sr_cl        = state == CLEAR;
        sr_din       = (state == LOAD) ? tx_lat : '0;
        sclk         = (state == BIT) && (div_cnt >= DIV_HALF);
        sdo          = (state == BIT) && (msb_lat ? sr_dout[WIDTH-1] : sr_dout[0]);
        sr_shl       = shift_now && msb_lat;
        sr_shr       = shift_now && !msb_lat;
        sr_shift_bit = shift_now && samp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            samp    <= 1'b0;
            msb_lat <= 1'b0;
            tx_lat  <= '0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            if (state == IDLE && !abort && start) begin
                msb_lat <= msb_first;
                tx_lat  <= tx_data;
            end
            if (state == LOAD) begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == BIT) begin
                div_cnt <= shift_now ? '0 : div_cnt + 1'b1;
                if (shift_now)
                    bit_cnt <= bit_cnt + 1'b1;
                // Capture at the edge that ends the first sclk-high cycle.
                if (div_cnt == DIV_HALF)
                    samp <= sdi;
            end
            // Abort in FINISH wins: no new word, no done.
            if (state == FINISH && !abort)
                rx_data <= sr_dout;
            done <= (state == FINISH) && !abort;
        end
    end
endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the 8-bit `registro_desp` shift register. It turns that register into a full-duplex synchronous serial port.
- On a `start` request it parallel-loads the word to send, then performs WIDTH timed shifts in the selected direction.
- It drives `sclk`/`sdo` and captures `sdi` into the vacated bit on each shift.
- It presents the received word with a `done` pulse.

It sits between the test-controller logic (requester) and the shift register (resource) in the measurement/7-seg test designs.

## Interface
- WIDTH, 8, word length; must equal the shift register width.
- DIV, 4, clk cycles per serial bit; even, >= 4.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- msb_first  in  1  direction, latched when start is accepted: 1 = MSB first (shift left), 0 = LSB first (shift right)
- abort  in  1  cancel current transfer; sampled every cycle
- tx_data  in  WIDTH  word to transmit, sampled with start
- busy  out  1  high from the accepting edge until the return to IDLE
- done  out  1  one-cycle pulse, rx_data valid
- rx_data  out  WIDTH  last completed received word
- sclk  out  1  serial clock, idle low
- sdo  out  1  serial data out
- sdi  in  1  serial data in
- sr_cl, sr_w, sr_shr, sr_shl, sr_shift_bit  out  1  shift-register controls
- sr_din  out  WIDTH  shift-register parallel load data
- sr_dout  in  WIDTH  shift-register contents

## Operation
- States: IDLE, LOAD, BIT, FINISH, CLEAR.
- IDLE:
  - busy=0.
  - abort -> CLEAR.
  - else start -> LOAD; latch msb_first and tx_data.
- LOAD: sr_w=1, sr_din=latched tx_data for exactly one cycle; -> BIT with div_cnt=0, bit_cnt=0.
- BIT:
  - div_cnt counts 0..DIV-1.
  - sclk=0 for div_cnt<DIV/2, sclk=1 otherwise.
  - sdo = sr_dout[WIDTH-1] if msb_first, else sr_dout[0]. sdo is combinational and 0 outside BIT.
  - div_cnt==DIV/2: register sdi into samp.
  - div_cnt==DIV-1: one-cycle sr_shl (msb_first) or sr_shr (otherwise) with sr_shift_bit=samp; div_cnt->0; bit_cnt+1.
  - Shift on bit_cnt==WIDTH-1 -> FINISH.
- FINISH: rx_data<=sr_dout at exit edge; done=1 registered for the following cycle; -> IDLE.
- CLEAR: sr_cl=1 for one cycle; no done; rx_data unchanged; -> IDLE.
- abort in LOAD/BIT/FINISH -> CLEAR at next edge. FINISH+abort: abort wins, rx_data not updated.
- start while busy is ignored (not queued). start+abort together in IDLE: abort wins.
- At most one of sr_cl/sr_w/sr_shr/sr_shl is high in any cycle. sr_din and sr_shift_bit are 0 when unused.

## Timing
- Reset (rst_n=0, immediate): state IDLE. busy, done, sclk, sdo, all sr_* and rx_data = 0. div_cnt, bit_cnt, samp = 0.
- rst_n low mid-transfer aborts at once, with no sr_cl pulse and no done. The shift register is cleared by its own reset path.
- start accepted at edge E0:
  - busy high from E0.
  - LOAD during cycle E0..E1.
  - BIT for WIDTH*DIV cycles.
  - FINISH for 1 cycle.
  - done high and busy low in the cycle after edge E0+WIDTH*DIV+2 (34 cycles for defaults).
- New start is accepted in the done cycle; back-to-back transfers run every WIDTH*DIV+2 cycles.
- sdi is sampled on the clk edge ending the first sclk-high cycle. sdo changes only after a shift edge, i.e. while sclk is low.
- abort at edge Ea: CLEAR in cycle Ea..Ea+1, IDLE with busy=0 from Ea+1.

## Test plan
- Loopback sdi=sdo, tx_data=0xA5, msb_first=0, start pulse: sdo bits per period 1,0,1,0,0,1,0,1; rx_data=0xA5; done exactly 34 cycles after start edge, one cycle wide.
- Loopback, tx_data=0x3C, msb_first=1: sdo sequence 0,0,1,1,1,1,0,0; sr_shl pulses 8 times, sr_shr never; rx_data=0x3C.
- sdi tied 1, tx_data=0x00: rx_data=0xFF; sclk shows 8 periods, 2 low + 2 high cycles each.
- abort asserted during bit 3: sr_cl high one cycle, busy low next cycle, no done, rx_data keeps prior value 0x3C.
- start re-pulsed mid-transfer and in the done cycle: first ignored; second starts a new transfer with LOAD immediately after.
- rst_n low for 1 cycle during bit 5: all outputs 0 immediately; after release, a fresh 0x5A loopback completes with rx_data=0x5A.
